ks_ram_responder: RTL and testbench
===================================

// Module: ks_ram_responder
// PURPOSE
//  Memory-side responder for the K&S multicycle core's data/instruction bus.
//  Accepts one read or write request at a time from the core's control/datapath side.
//  Models a RAM with a configurable wait-state count and returns a one-cycle response pulse.
//  Sits between the core's address mux / write-enable outputs and the word storage array.
// PARAMETERS
//  ADDR_W       5     request address width (words)
//  DATA_W       16    data word width
//  MEM_DEPTH    32    implemented words; MEM_DEPTH <= 2**ADDR_W
//  WAIT_STATES  1     extra cycles between acceptance and response (0..15)
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  req_valid    in   1        request present
//  req_write    in   1        1 = write, 0 = read
//  req_addr     in   ADDR_W   word address
//  req_wdata    in   DATA_W   write data
//  req_ready    out  1        responder idle, request accepted this cycle if req_valid
//  rsp_valid    out  1        one-cycle response pulse
//  rsp_rdata    out  DATA_W   read data (reads) / echo of written data (writes)
//  rsp_err      out  1        qualifies rsp_valid: address >= MEM_DEPTH
//  rd_count     out  16       completed reads (KS_RAM_STATS_EN), else 0
//  wr_count     out  16       completed writes (KS_RAM_STATS_EN), else 0
// BEHAVIOUR
//  - Reset: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counters=0; storage NOT cleared.
//  - req_ready = (state==IDLE) && !rst; decoded from state, no registered delay.
//  - Accept on edge where req_valid && req_ready: latch write/addr/wdata;
//    next state WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES-1), else RESP.
//  - WAIT: counter decrements each cycle; at 0 -> RESP. Inputs ignored.
//  - RESP (exactly one cycle): rsp_valid=1 registered out of this state;
//    write: mem[addr]<=wdata on the edge leaving RESP, rsp_rdata=wdata;
//    read: rsp_rdata=mem[addr] (pre-write contents). Next state IDLE.
//  - Latency: accept at edge N -> rsp_valid high in cycle after edge N+WAIT_STATES+1.
//  - No response back-pressure; consumer must sample rsp_valid when it is high.
//  - Back-to-back: new request accepted the cycle after RESP (IDLE cycle), never during RESP.
//  - Out of range (addr >= MEM_DEPTH): write dropped, read returns 0, rsp_err=1 with rsp_valid.
//  - rsp_rdata/rsp_err hold last value when rsp_valid=0.
//  - Reset mid-operation (WAIT or RESP): pending access discarded, no write, no response.
//  - Counters saturate at 16'hFFFF; err responses are not counted.
// CONFIGURATION
//  KS_RAM_STATS_EN defined: rd_count/wr_count increment on each non-error RESP.
//  Not defined: counter registers absent, rd_count=wr_count=16'd0 constantly.
// STRUCTURE
//  k_and_s_pkg: ks_ram_state_t enum {RAM_IDLE, RAM_WAIT, RAM_RESP}, KS_RAM_CNT_W=16.
//  Sub-module ks_ram_array: DATA_W x MEM_DEPTH storage, one sync write port,
//  async read port; no reset. FSM, counter, range check stay in ks_ram_responder.
// TESTING (WAIT_STATES=2, MEM_DEPTH=32 unless noted)
//  1 rst 1 cycle -> req_ready=1, rsp_valid=0, counters 0 on first cycle after reset.
//  2 write addr 5 data 16'hBEEF -> rsp_valid 3 cycles after accept, rdata=BEEF, err=0;
//    read addr 5 -> rdata=16'hBEEF.
//  3 hold req_valid continuously, 4 reads -> req_ready low 3 cycles between accepts,
//    one rsp_valid pulse per read, rd_count=4 (STATS_EN).
//  4 MEM_DEPTH=24: write addr 30 data 1234 -> rsp_err=1; read addr 30 -> rdata=0, err=1;
//    wr_count unchanged.
//  5 write addr 7 data 16'h00AA, assert rst during WAIT -> no rsp_valid; read addr 7
//    returns prior contents.
//  6 WAIT_STATES=0: read accepted at edge N -> rsp_valid in cycle after edge N+1.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared types and helpers for the K&S RAM responder
//
// Purpose: state encoding for the responder FSM, statistics counter width
//          and a saturating increment helper.
// Ports:   none (package).
package k_and_s_pkg;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_RESP = 2'd2
    } ks_ram_state_t;

    localparam int KS_RAM_CNT_W = 16;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [KS_RAM_CNT_W-1:0] ks_sat_inc(input logic [KS_RAM_CNT_W-1:0] v);
        return (v == '1) ? v : v + KS_RAM_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ks_ram_array.sv
// rtl/ks_ram_array.sv - word storage with one sync write port and async read
//
// Purpose: DATA_W x MEM_DEPTH storage array. Contents are never reset.
//          Callers must keep i_addr in range when i_we is set; read data
//          for out-of-range addresses is meaningless and must be masked.
// Ports:
//   clk      in   1        write clock
//   i_we     in   1        write enable
//   i_addr   in   ADDR_W   shared read/write word address
//   i_wdata  in   DATA_W   write data
//   o_rdata  out  DATA_W   combinational read of i_addr
module ks_ram_array #(
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ks_ram_responder.sv
// rtl/ks_ram_responder.sv - single-outstanding RAM responder with wait states
//
// Purpose: accepts one read/write at a time, waits WAIT_STATES cycles, then
//          issues a one-cycle response pulse. Addresses >= MEM_DEPTH are
//          flagged with rsp_err; such writes are dropped and reads return 0.
// Optional feature: define KS_RAM_STATS_EN to enable the saturating
//          completed read/write counters; otherwise both read as zero.
// Ports:
//   clk        in   1        clock, posedge
//   rst        in   1        synchronous active-high reset
//   req_valid  in   1        request present
//   req_write  in   1        1 = write, 0 = read
//   req_addr   in   ADDR_W   word address
//   req_wdata  in   DATA_W   write data
//   req_ready  out  1        idle; request taken this cycle if req_valid
//   rsp_valid  out  1        one-cycle response pulse
//   rsp_rdata  out  DATA_W   read data, or echo of write data
//   rsp_err    out  1        address out of range (qualified by rsp_valid)
//   rd_count   out  16       completed non-error reads
//   wr_count   out  16       completed non-error writes
module ks_ram_responder
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int MEM_DEPTH   = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [KS_RAM_CNT_W-1:0] rd_count,
    output logic [KS_RAM_CNT_W-1:0] wr_count
);

    ks_ram_state_t     r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_in_range;
    logic              w_we;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_in_range = (32'(r_addr) < MEM_DEPTH);
    // The write lands on the edge that leaves RESP; a reset on that edge
    // discards it.
    assign w_we       = (r_state == RAM_RESP) && r_write && w_in_range && !rst;
    assign req_ready  = (r_state == RAM_IDLE) && !rst;

    ks_ram_array #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RAM_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                RAM_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (WAIT_STATES > 0) begin
                            r_state <= RAM_WAIT;
                            r_cnt   <= 4'(WAIT_STATES - 1);
                        end else begin
                            r_state <= RAM_RESP;
                        end
                    end
                end
                RAM_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RAM_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RAM_RESP: begin
                    // Read data is sampled before this edge's write lands.
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= !w_in_range;
                    r_rsp_rdata <= r_write    ? r_wdata     :
                                   w_in_range ? w_mem_rdata : '0;
                    r_state     <= RAM_IDLE;
                end
                default: r_state <= RAM_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

`ifdef KS_RAM_STATS_EN
    logic [KS_RAM_CNT_W-1:0] r_rd_count;
    logic [KS_RAM_CNT_W-1:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if ((r_state == RAM_RESP) && w_in_range) begin
            if (r_write) begin
                r_wr_count <= ks_sat_inc(r_wr_count);
            end else begin
                r_rd_count <= ks_sat_inc(r_rd_count);
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_ks_ram_responder.sv
// tb/tb_ks_ram_responder.sv - scoreboard bench for ks_ram_responder
module tb_ks_ram_responder;

    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 24;
    localparam int WS    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    ks_ram_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            when;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            exp_rd = 0;
    int            exp_wr = 0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Leaves req_valid high so a following call is accepted back-to-back.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   k;
        int   low;
        exp_t e;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        k = 0;
        while (!req_ready && k < 50) begin
            tick();
            k++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        e.err   = (int'(a) >= DEPTH);
        e.rdata = w ? d : (e.err ? '0 : model_mem[a]);
        e.when  = cyc + WS + 2;
        sb.push_back(e);
        if (!e.err) begin
            if (w) begin
                model_mem[a] = d;
                if (exp_wr < 16'hFFFF) exp_wr++;
            end else begin
                if (exp_rd < 16'hFFFF) exp_rd++;
            end
        end
        tick();
        low = 0;
        while (!req_ready && low < 50) begin
            low++;
            tick();
        end
        check("ready_low_cycles", 32'(low), 32'(WS + 1));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_latency", 32'(cyc), 32'(e.when));
                    last_rdata = e.rdata;
                    last_err   = e.err;
                end
            end else begin
                check("hold_rdata", 32'(rsp_rdata), 32'(last_rdata));
                check("hold_err", 32'(rsp_err), 32'(last_err));
            end
        end
    end

    initial begin
        int k;
        int exp_rd_cnt;
        int exp_wr_cnt;

        tick();
        tick();
        check("ready_in_reset", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rd_count", 32'(rd_count), 32'd0);
        check("reset_wr_count", 32'(wr_count), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Give every in-range word a known value before any read.
        for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), 16'($urandom));
        idle(1);

        issue(1'b1, 5'd5, 16'hBEEF);
        issue(1'b0, 5'd5, 16'h0);
        idle(2);
        issue(1'b1, 5'd30, 16'h1234);
        issue(1'b0, 5'd30, 16'h0);
        issue(1'b0, 5'd23, 16'h0);
        issue(1'b0, 5'd24, 16'h0);
        idle(1);

        // Reset while the write to address 7 is waiting: it must vanish.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd7;
        req_wdata = 16'h00AA;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_rdata = '0;
        last_err   = 1'b0;
        exp_rd     = 0;
        exp_wr     = 0;
        #1;
        check("ready_after_midreset", 32'(req_ready), 32'd1);
        check("rdcnt_after_midreset", 32'(rd_count), 32'd0);
        idle(6);
        issue(1'b0, 5'd7, 16'h0);
        idle(1);

        repeat (80) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 16'($urandom));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        k = 0;
        while (sb.size() > 0 && k < 50) begin
            tick();
            k++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        idle(2);

`ifdef KS_RAM_STATS_EN
        exp_rd_cnt = exp_rd;
        exp_wr_cnt = exp_wr;
`else
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
`endif
        check("rd_count", 32'(rd_count), 32'(exp_rd_cnt));
        check("wr_count", 32'(wr_count), 32'(exp_wr_cnt));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
